seg_scan_arbiter: RTL and testbench
===================================

// Module: seg_scan_arbiter
// PURPOSE
//  Time-multiplexed controller for the 4-digit 7-segment display, shared between two requesters.
//  Generates the digit-scan timing with inter-digit blanking.
//  Grants the display to one requester per frame; changes owner only at frame boundaries, with round-robin and a hold time.
//  Snapshots the owner's 4 digit patterns into a frame buffer so the display never tears.
// PARAMETERS
//  SCAN_DIV     2500  clk cycles per digit slot (>=2)
//  BLANK_CYC    16    cycles at slot start with all digits off (0..SCAN_DIV-1; 0 = no blanking)
//  HOLD_FRAMES  64    min frames the owner keeps the grant while the other requester waits (>=1)
// PORTS
//  clk         in   1   system clock, single domain
//  rst         in   1   synchronous, active-high reset
//  req         in   2   req[i]=1: requester i wants the display (level)
//  digits0     in   28  requester 0 patterns: [6:0]=digit0 .. [27:21]=digit3
//  digits1     in   28  requester 1 patterns, same packing
//  grant       out  2   one-hot current owner; 2'b00 = idle
//  seg         out  7   segment pattern of the scanned digit
//  segen       out  4   digit enables, active-low (digit k on = bit k low)
//  frame_done  out  1   1-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset: seg=7'h00, segen=4'hF, grant=2'b00, frame_done=0, slot_cnt=0, dig_idx=0, hold=0, last=1, state=IDLE, fbuf=0.
//  Scan timer:
//   - slot_cnt counts 0..SCAN_DIV-1 and wraps.
//   - On wrap, dig_idx advances 0->1->2->3->0.
//   - Frame boundary fb = (slot_cnt==SCAN_DIV-1 && dig_idx==3).
//   - Frame length is 4*SCAN_DIV cycles and runs regardless of grant.
//  Outputs are registered, one cycle behind the counters:
//   - seg   <= (state==IDLE) ? 0 : fbuf[dig_idx]
//   - segen <= (state==IDLE || slot_cnt<BLANK_CYC) ? 4'hF : ~(4'b0001<<dig_idx)
//  FSM states: IDLE, OWN0, OWN1. grant = {state==OWN1, state==OWN0}. Evaluated ONLY on the fb edge:
//   - IDLE: if both req, take the requester != last; if one req, take it; else stay IDLE.
//   - OWNi: switch to OWNj (j!=i) if req[j] && (!req[i] || hold>=HOLD_FRAMES).
//   - OWNi: go to IDLE if !req[i] && !req[j].
//   - OWNi: otherwise stay.
//   - On entering OWNi: last<=i, hold<=0.
//   - On staying: hold<=hold+1, saturating at HOLD_FRAMES.
//  On the same fb edge:
//   - fbuf <= digits of the NEW owner (unchanged if the new state is IDLE).
//   - frame_done<=1. grant updates on this edge.
//  Latency: the owner's digit0 appears on seg the cycle after fb.
//   - segen stays off for BLANK_CYC cycles after that, then shows 4'b1110.
//  Mid-frame changes of digitsX or req have no effect until the next fb.
//   - A dropped owner stays displayed until fb.
//  hold width = $clog2(HOLD_FRAMES+1). All counters wrap or saturate exactly as stated; no overflow.
//  rst mid-frame: all regs take reset values on that edge. The frame restarts at slot 0 / digit 0.
// STRUCTURE
//  Package seg_pkg:
//   - state enum {IDLE,OWN0,OWN1}
//   - SEG_BLANK=7'h00, SEGEN_OFF=4'hF
//   - function digit_en(idx) returning the active-low one-hot enable
//  Sub-module seg_scan_timer: slot_cnt, dig_idx, fb, in_blank; parameters SCAN_DIV and BLANK_CYC.
//  Top level holds the FSM, hold counter, fbuf and output registers.
// TESTING (bench: SCAN_DIV=8, BLANK_CYC=2, HOLD_FRAMES=3; frame = 32 cycles)
//  1 Reset, req=00 for 5 frames -> grant=00, segen=4'hF, seg=0 throughout; frame_done every 32 cycles.
//  2 req=01, digits0={7'h4F,7'h5B,7'h06,7'h3F} -> after the first fb: grant=01.
//    Per slot: 2 cycles segen=1111, then 6 cycles segen=1110 with seg=7'h3F, then 1101 with seg=7'h06, etc.
//  3 req=11 from reset -> grant=01 for 4 frames (hold 0..3), then 10 for 4 frames, then alternating.
//    No glitch on grant between fb edges.
//  4 While owning, change digits0 at mid-frame -> seg keeps the old patterns until the next fb.
//    The new patterns appear from digit0 of the next frame.
//  5 Owner 0 drops req at cycle 10 of a frame, req1=1 -> grant=01 until fb, then 10 with hold=0.
//    With req=00 instead -> IDLE and segen=4'hF after fb.
//  6 Assert rst for 1 cycle at slot 5 of digit 2 -> next cycle all outputs at reset values.
//    The next frame_done comes exactly 32 cycles after rst is released.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the segment scan arbiter.
//   state_t   : arbiter FSM state (IDLE / OWN0 / OWN1)
//   SEG_BLANK : segment pattern driven while no digit is shown
//   SEGEN_OFF : active-low digit enables with every digit dark
//   digit_en  : active-low one-hot enable for a digit index
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [3:0] SEGEN_OFF = 4'hF;

    function automatic logic [3:0] digit_en(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-scan timebase: a slot counter of SCAN_DIV cycles per digit and a
// 2-bit digit index. Free-running; the frame boundary does not depend on
// who owns the display.
//   clk, rst  : clock, synchronous active-high reset
//   dig_idx   : digit currently being scanned (0..3)
//   fb        : high in the last cycle of digit 3 (frame boundary)
//   in_blank  : high in the first BLANK_CYC cycles of each slot
module seg_scan_timer #(
    parameter int SCAN_DIV  = 2500,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] dig_idx,
    output logic       fb,
    output logic       in_blank
);

    localparam int             CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] slot_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= 2'd0;
        end else if (slot_cnt == LAST) begin
            slot_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;   // 3 wraps to 0
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign fb = (slot_cnt == LAST) && (dig_idx == 2'd3);

    // Compared at 32 bits so BLANK_CYC=0 simply never blanks.
    assign in_blank = 32'(slot_cnt) < BLANK_CYC;

endmodule

// File: rtl/seg_scan_arbiter.sv
// Two-requester arbiter and scan driver for a 4-digit 7-segment display.
// Ownership changes only at frame boundaries (round-robin with a minimum
// hold); the owner's patterns are snapshotted into fbuf at each boundary so
// a frame is never torn by mid-frame input changes.
//   clk, rst   : clock, synchronous active-high reset
//   req[1:0]   : level requests, one per requester
//   digits0/1  : 4 x 7-bit patterns, digit0 in [6:0] .. digit3 in [27:21]
//   grant      : one-hot owner, 2'b00 when idle
//   seg        : segment pattern of the scanned digit (registered)
//   segen      : active-low digit enables (registered)
//   frame_done : one-cycle pulse after each frame boundary
module seg_scan_arbiter
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 2500,
    parameter int BLANK_CYC   = 16,
    parameter int HOLD_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [27:0] digits0,
    input  logic [27:0] digits1,
    output logic [1:0]  grant,
    output logic [6:0]  seg,
    output logic [3:0]  segen,
    output logic        frame_done
);

    localparam int            HW     = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_L = HW'(HOLD_FRAMES);

    state_t          state, nxt;
    logic            last;       // most recent owner, breaks ties from IDLE
    logic [HW-1:0]   hold;       // frames the current owner has kept the grant
    logic [3:0][6:0] fbuf;
    logic [1:0]      dig_idx;
    logic            fb, in_blank;

    seg_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .dig_idx  (dig_idx),
        .fb       (fb),
        .in_blank (in_blank)
    );

    // Next owner; only consumed on the frame-boundary cycle.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req == 2'b11)  nxt = last ? OWN0 : OWN1;
                else if (req[0])   nxt = OWN0;
                else if (req[1])   nxt = OWN1;
            end
            OWN0: begin
                if (req[1] && (!req[0] || hold >= HOLD_L)) nxt = OWN1;
                else if (!req[0])                          nxt = IDLE;
            end
            OWN1: begin
                if (req[0] && (!req[1] || hold >= HOLD_L)) nxt = OWN0;
                else if (!req[1])                          nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            hold       <= '0;
            fbuf       <= '0;
            seg        <= SEG_BLANK;
            segen      <= SEGEN_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fb;
            // Outputs follow the counters by one cycle.
            seg   <= (state == IDLE) ? SEG_BLANK : fbuf[dig_idx];
            segen <= (state == IDLE || in_blank) ? SEGEN_OFF : digit_en(dig_idx);
            if (fb) begin
                state <= nxt;
                // Idle keeps the stale buffer; it is masked by seg anyway.
                if (nxt == OWN0)      fbuf <= digits0;
                else if (nxt == OWN1) fbuf <= digits1;
                if (nxt != IDLE && nxt != state) begin
                    last <= (nxt == OWN1);
                    hold <= '0;
                end else if (nxt != IDLE && hold != HOLD_L) begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

    assign grant = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench: each scenario fills a per-frame owner/pattern table by
// hand, expands it into per-cycle expected outputs, and a monitor compares
// them against the DUT on the falling edge.
module tb_seg_scan_arbiter;

    localparam logic [27:0] D0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [27:0] D1 = {7'h07, 7'h7D, 7'h6D, 7'h66};
    localparam logic [27:0] D2 = {7'h7F, 7'h6F, 7'h77, 7'h39};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [27:0] digits0 = '0;
    logic [27:0] digits1 = '0;
    logic [1:0]  grant;
    logic [6:0]  seg;
    logic [3:0]  segen;
    logic        frame_done;

    seg_scan_arbiter #(
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .HOLD_FRAMES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .digits0    (digits0),
        .digits1    (digits1),
        .grant      (grant),
        .seg        (seg),
        .segen      (segen),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        string      nm;
        logic [1:0] grant;
        logic [6:0] seg;
        logic [3:0] segen;
        logic       fd;
    } exp_t;

    exp_t        q[$];
    int          t = 0;          // cycles since the last reset edge
    int          checks = 0;
    int          failures = 0;
    int          own[16];        // 0 idle, 1 owner 0, 2 owner 1, per frame
    logic [27:0] pat[16];        // frame buffer contents per frame

    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].t <= t) begin
                e = q.pop_front();
                checks++;
                if (e.t != t) begin
                    failures++;
                    $display("FAIL %s t=%0d: expectation skipped (now t=%0d)", e.nm, e.t, t);
                end else if ({grant, seg, segen, frame_done} !== {e.grant, e.seg, e.segen, e.fd}) begin
                    failures++;
                    $display("FAIL %s t=%0d got grant=%b seg=%h segen=%b fd=%b, want grant=%b seg=%h segen=%b fd=%b",
                             e.nm, t, grant, seg, segen, frame_done, e.grant, e.seg, e.segen, e.fd);
                end
            end
        end
    end

    task automatic set_frames(input int a, input int b, input int o, input logic [27:0] p);
        for (int k = a; k <= b; k++) begin
            own[k] = o;
            pat[k] = p;
        end
    endtask

    // Outputs in cycle k reflect state/counters of cycle k-1; frames are 32 cycles.
    task automatic push_plan(input string nm, input int nfr, input int tmax);
        int last_t;
        last_t = 32 * nfr - 1;
        if (tmax < last_t) last_t = tmax;
        for (int k = 0; k <= last_t; k++) begin
            exp_t e;
            int p, fr, d;
            e.t     = k;
            e.nm    = nm;
            e.grant = (own[k/32] == 1) ? 2'b01 : (own[k/32] == 2) ? 2'b10 : 2'b00;
            e.fd    = (k % 32 == 0) && (k > 0);
            if (k == 0) begin
                e.seg   = 7'h00;
                e.segen = 4'hF;
            end else begin
                p  = k - 1;
                fr = p / 32;
                d  = (p / 8) % 4;
                e.seg   = (own[fr] == 0) ? 7'h00 : pat[fr][7*d +: 7];
                e.segen = (own[fr] == 0 || p % 8 < 2) ? 4'hF : ~(4'b0001 << d);
            end
            q.push_back(e);
        end
    endtask

    task automatic do_reset(input string nm, input int nfr, input int tmax,
                            input logic [1:0] r, input logic [27:0] d0, input logic [27:0] d1);
        req     = r;
        digits0 = d0;
        digits1 = d1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        push_plan(nm, nfr, tmax);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the caller at the falling edge of cycle 'when'.
    task automatic goto(input int when);
        int n;
        n = 0;
        while (t != when && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (t != when) begin
            checks++;
            failures++;
            $display("FAIL goto t=%0d never reached %0d", t, when);
        end
    endtask

    initial begin
        // 1: idle for 5 frames
        set_frames(0, 15, 0, '0);
        do_reset("s1_idle", 5, 9999, 2'b00, D0, D1);
        goto(159);

        // 2: single requester 0
        set_frames(0, 15, 0, '0);
        set_frames(1, 2, 1, D0);
        do_reset("s2_own0", 3, 9999, 2'b01, D0, D1);
        goto(95);

        // 3: both requesting, round-robin with hold of 3
        set_frames(0, 15, 0, '0);
        set_frames(1, 4, 1, D0);
        set_frames(5, 8, 2, D1);
        set_frames(9, 12, 1, D0);
        do_reset("s3_rr", 13, 9999, 2'b11, D0, D1);
        goto(415);

        // 4: mid-frame pattern change takes effect next frame
        set_frames(0, 15, 0, '0);
        set_frames(1, 1, 1, D0);
        set_frames(2, 2, 1, D2);
        do_reset("s4_tear", 3, 9999, 2'b01, D0, D1);
        goto(48);
        digits0 = D2;
        goto(95);

        // 5a: owner 0 drops, owner 1 takes over with hold restarted
        set_frames(0, 15, 0, '0);
        set_frames(1, 1, 1, D0);
        set_frames(2, 5, 2, D1);
        set_frames(6, 6, 1, D0);
        do_reset("s5_drop", 7, 9999, 2'b01, D0, D1);
        goto(42);
        req = 2'b10;
        goto(70);
        req = 2'b11;
        goto(223);

        // 5b: owner drops with nobody waiting
        set_frames(0, 15, 0, '0);
        set_frames(1, 1, 1, D0);
        do_reset("s5_idle", 3, 9999, 2'b01, D0, D1);
        goto(42);
        req = 2'b00;
        goto(95);

        // 6: reset at slot 5 of digit 2, frame restarts
        set_frames(0, 15, 0, '0);
        set_frames(1, 1, 1, D0);
        do_reset("s6_pre", 2, 53, 2'b01, D0, D1);
        goto(53);
        do_reset("s6_post", 2, 9999, 2'b01, D0, D1);
        goto(63);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
